// File: rtl/spi_master.sv
// spi_master: single-frame SPI master, all four modes, MSB first, no chip select.
// sclk toggles every CLKS_PER_HALF clk cycles for 2*FRAME_WIDTH edges per frame.
module spi_master #(
  parameter int FRAME_WIDTH   = 8,
  parameter int CLKS_PER_HALF = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [FRAME_WIDTH-1:0] din,
  input  logic                   tx_start,
  output logic                   tx_ready,
  output logic [FRAME_WIDTH-1:0] dout,
  output logic                   rx_done,
  input  logic                   miso,
  output logic                   mosi,
  output logic                   sclk
);
  localparam int CW  = $clog2(CLKS_PER_HALF + 1);
  localparam int KW  = $clog2(2 * FRAME_WIDTH + 1);
  localparam int MSB = FRAME_WIDTH - 1;
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic [MSB:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, cpha_q, cpha_d, rx_done_q, rx_done_d;
  logic start, tick, lead, last;
  assign start = (state_q == IDLE) && tx_start;
  assign tick  = (state_q == XFER) && (cnt_q == CW'(CLKS_PER_HALF - 1));
  assign lead  = ~k_q[0];
  assign last  = k_q == KW'(2 * FRAME_WIDTH - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && tx_start) state_d = XFER;
    else if (tick && last)           state_d = IDLE;
  end
  always_comb begin
    tx_ready = state_q == IDLE;
    sclk     = (state_q == IDLE) ? mode[1] : sclk_q;
    mosi     = (state_q == IDLE) ? 1'b0 : mosi_q;
    rx_done  = rx_done_q;
    dout     = dout_q;
  end
  // Shift edges: trailing for CPHA=0 (MSB preloaded at start), leading for CPHA=1.
  always_comb begin
    cnt_d     = cnt_q;
    k_d       = k_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cpha_d    = cpha_q;
    rx_done_d = 1'b0;
    if (start) begin
      cnt_d  = '0;
      k_d    = '0;
      rx_d   = '0;
      cpha_d = mode[0];
      sclk_d = mode[1];
      mosi_d = mode[0] ? 1'b0 : din[MSB];
      tx_d   = mode[0] ? din : din << 1;
    end else if (state_q == XFER) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        k_d    = k_q + KW'(1);
        sclk_d = ~sclk_q;
        if (lead == cpha_q && !last) begin
          mosi_d = tx_q[MSB];
          tx_d   = tx_q << 1;
        end
        if (lead != cpha_q) rx_d = {rx_q[MSB-1:0], miso};
        if (last) begin
          dout_d    = rx_d;
          rx_done_d = 1'b1;
          mosi_d    = 1'b0;
          k_d       = '0;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q     <= '0;
      k_q       <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      dout_q    <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cpha_q    <= 1'b0;
      rx_done_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      dout_q    <= dout_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cpha_q    <= cpha_d;
      rx_done_q <= rx_done_d;
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed and random frames against a bench-side SPI slave model.
module tb_spi_master;
  logic clk = 1'b0;
  logic reset, tx_start, miso, mosi, sclk, tx_ready, rx_done;
  logic [1:0] mode;
  logic [7:0] din, dout;
  logic loop, slave_bit;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  assign miso = loop ? mosi : slave_bit;
  spi_master dut (
    .clk(clk), .reset(reset), .mode(mode), .din(din), .tx_start(tx_start),
    .tx_ready(tx_ready), .dout(dout), .rx_done(rx_done),
    .miso(miso), .mosi(mosi), .sclk(sclk)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // The slave shifts miso on the edges opposite to the ones the master samples on.
  task automatic run_frame(input logic [1:0] m, input logic [7:0] d, input logic [7:0] s,
                           input logic lp, input logic poke);
    int busy = 0, rxd = 0, edges = 0, sh = 0, idx, mosi_hi = 0;
    logic ps, pm, done = 1'b0;
    logic [7:0] cap = '0;
    mode = m; loop = lp; slave_bit = s[7];
    @(negedge clk);
    chk("idle_sclk", sclk, m[1]);
    chk("idle_mosi", mosi, 0);
    chk("idle_ready", tx_ready, 1);
    din = d; tx_start = 1'b1; ps = sclk; pm = mosi;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      tx_start = 1'b0;
      din = 8'($urandom);
      if (poke && c == 9) begin tx_start = 1'b1; din = 8'hFF; end
      if (poke && c == 5) mode = ~m;
      if (poke && c == 20) mode = m;
      if (!tx_ready) busy++;
      if (mosi) mosi_hi++;
      if (rx_done) rxd++;
      if (sclk !== ps) begin
        edges++;
        if (edges[0] != m[0]) cap = {cap[6:0], pm};
        else sh++;
      end
      idx = m[0] ? sh - 1 : sh;
      slave_bit = (idx >= 0 && idx < 8) ? s[7-idx] : 1'b0;
      ps = sclk; pm = mosi;
      if (tx_ready) done = 1'b1;
    end
    chk("done", done, 1);
    chk("busy_cycles", busy, 32);
    chk("rx_done_count", rxd, 1);
    chk("sclk_edges", edges, 16);
    chk("mosi_bits", cap, d);
    chk("dout", dout, lp ? d : s);
    chk("end_sclk", sclk, m[1]);
    chk("end_mosi", mosi, 0);
    if (d == 8'h00) chk("mosi_zero", mosi_hi, 0);
    @(negedge clk);
    chk("rx_done_pulse", rx_done, 0);
    chk("dout_hold", dout, lp ? d : s);
  endtask
  initial begin
    reset = 1'b1; tx_start = 1'b0; mode = 2'b10; din = '0; loop = 1'b1; slave_bit = 1'b0;
    #1;
    chk("rst_ready", tx_ready, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_dout", dout, 0);
    chk("rst_rx_done", rx_done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_frame(2'b00, 8'hA5, 8'h00, 1'b1, 1'b0);
    run_frame(2'b00, 8'h3C, 8'h00, 1'b1, 1'b0);
    run_frame(2'b00, 8'hD5, 8'h00, 1'b1, 1'b0);
    run_frame(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    run_frame(2'b01, 8'hA5, 8'h00, 1'b1, 1'b0);
    run_frame(2'b10, 8'hA5, 8'h00, 1'b1, 1'b0);
    run_frame(2'b11, 8'hA5, 8'h00, 1'b1, 1'b0);
    run_frame(2'b00, 8'h5A, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      run_frame(2'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'($urandom));
    mode = 2'b10; loop = 1'b1;
    @(negedge clk);
    din = 8'h3C; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", tx_ready, 0);
    reset = 1'b1;
    #1;
    chk("abort_ready", tx_ready, 1);
    chk("abort_sclk", sclk, 1);
    chk("abort_mosi", mosi, 0);
    chk("abort_dout", dout, 0);
    chk("abort_rx_done", rx_done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rx_done", rx_done, 0);
    end
    run_frame(2'b00, 8'hC3, 8'h00, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 8, meaning bits per frame (legal >= 2).
REQ-002 SHALL have parameter CLKS_PER_HALF, default 2, meaning clk cycles per sclk half-period (legal >= 1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mode  input  2  SPI mode: mode[1]=CPOL, mode[0]=CPHA.
REQ-006 SHALL have port din  input  FRAME_WIDTH  transmit frame, MSB sent first.
REQ-007 SHALL have port tx_start  input  1  one-cycle start request.
REQ-008 SHALL have port tx_ready  output  1  high = idle, able to accept tx_start.
REQ-009 SHALL have port dout  output  FRAME_WIDTH  last received frame, MSB received first.
REQ-010 SHALL have port rx_done  output  1  one-cycle pulse when dout is updated.
REQ-011 SHALL have port miso  input  1  serial data from slave.
REQ-012 SHALL have port mosi  output  1  serial data to slave.
REQ-013 SHALL have port sclk  output  1  SPI serial clock.
- No chip-select port.

Function
REQ-014 SHALL implement two states, IDLE and XFER: IDLE->XFER on tx_start=1; XFER->IDLE after the final sclk edge.
REQ-015 SHALL assert tx_ready only in IDLE and ignore tx_start while in XFER.
REQ-016 SHALL, on the clk edge sampling tx_start=1 in IDLE (edge E0):
- latch din and mode;
- deassert tx_ready;
- for CPHA=0, drive mosi = din[FRAME_WIDTH-1].
REQ-017 SHALL toggle sclk at edges E0 + k*CLKS_PER_HALF, k = 1..2*FRAME_WIDTH, giving exactly FRAME_WIDTH sclk pulses per frame.
REQ-018 SHALL hold sclk at CPOL whenever idle; in IDLE, sclk follows the current mode[1].
REQ-019 SHALL, for CPHA=0:
- sample miso on every leading (odd-k) edge, shifting into the receive register MSB-first;
- drive the next mosi bit on every trailing (even-k) edge except the last.
REQ-020 SHALL, for CPHA=1:
- drive the next mosi bit (MSB first) on every leading edge;
- sample miso on every trailing edge, including the last.
REQ-021 SHALL, on edge k = 2*FRAME_WIDTH (E0 + 2*FRAME_WIDTH*CLKS_PER_HALF):
- return to IDLE;
- set tx_ready=1, rx_done=1;
- load dout with all FRAME_WIDTH received bits.
- Total busy time = 2*FRAME_WIDTH*CLKS_PER_HALF cycles (32 with defaults).
REQ-022 SHALL deassert rx_done on the following clk edge; dout holds its value until the next frame completes.
REQ-023 SHALL drive mosi low in IDLE.
REQ-024 SHALL accept tx_start on the same edge that tx_ready rises is not required; a new tx_start is accepted on any edge where the state is IDLE, giving back-to-back frames.
REQ-025 SHALL ignore mode and din changes during XFER.

Reset
REQ-026 SHALL, while reset=1 (asynchronously, including mid-frame):
- abort any frame and enter IDLE;
- set tx_ready=1, rx_done=0, dout=0, mosi=0, sclk=mode[1];
- clear shift registers and counters.
REQ-027 SHALL resume normal operation on the first clk edge after reset deasserts, without a spurious rx_done.

Verification
REQ-028 Mode 0, miso tied to mosi, send 8'hA5, then 8'h3C, then 8'hD5 -> each frame: rx_done one-cycle pulse, dout = sent byte, tx_ready low exactly 32 cycles.
REQ-029 Mode 0 loopback, send 8'h00 -> mosi stays 0; 8 sclk pulses with idle low; dout=8'h00.
REQ-030 Modes 1, 2, 3 loopback, send 8'hA5 -> dout=8'hA5; sclk idles at CPOL; data edges match CPHA per REQ-019/020.
REQ-031 Pulse tx_start with 8'hFF mid-frame of 8'h5A -> ignored; dout=8'h5A; exactly one rx_done pulse.
REQ-032 Assert reset at cycle 10 of a frame -> immediately tx_ready=1, sclk=CPOL, mosi=0, dout=0; no rx_done; next frame 8'hC3 completes correctly.
